// File: rtl/chr_bus_arbiter_pkg.sv
// chr_bus_arbiter_pkg: shared cartridge encodings for the CHR bus arbiter and nametable decode
package chr_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PPU_ISSUE = 3'd1,
      PPU_CAPT  = 3'd2,
      LDR_WR    = 3'd3,
      DONE      = 3'd4
   } arb_state_t;

   typedef enum logic [1:0] {
      MIR_VERT  = 2'b00,
      MIR_HORZ  = 2'b01,
      MIR_SCR_A = 2'b10,
      MIR_SCR_B = 2'b11
   } mirror_t;

   localparam int STARVE_W = 4;

   // saturating step of the loader starvation counter
   function automatic logic [STARVE_W-1:0] starve_next(input logic [STARVE_W-1:0] cnt,
                                                       input logic [STARVE_W-1:0] lim);
      return (cnt < lim) ? cnt + 1'b1 : cnt;
   endfunction

endpackage

// File: rtl/chr_bus_arbiter_nt_mirror_decode.sv
// nt_mirror_decode: nametable RAM select and A10 bank from PPU address and mirroring mode
module nt_mirror_decode
   import chr_bus_arbiter_pkg::*;
(
   input  logic [1:0] cfg_mirror,
   input  logic       a13,
   input  logic       a11,
   input  logic       a10,
   output logic       ciram_ce,
   output logic       ciram_a10
);

   // select is active-low over the nametable window; bank follows the live mirroring mode
   always_comb begin
      ciram_ce  = ~a13;
      ciram_a10 = (cfg_mirror == MIR_VERT) ? a10 :
                  (cfg_mirror == MIR_HORZ) ? a11 :
                  (cfg_mirror == MIR_SCR_B);
   end

endmodule

// File: rtl/chr_bus_arbiter.sv
// chr_bus_arbiter: shares one CHR RAM port between the PPU and a loader with starvation guard
module chr_bus_arbiter
   import chr_bus_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
)
(
   input  logic        MasterClk,
   input  logic        nRST,
   input  logic        ppu_req,
   input  logic        ppu_we,
   input  logic [13:0] ppu_addr,
   input  logic [7:0]  ppu_wdata,
   output logic [7:0]  ppu_rdata,
   output logic        ppu_ack,
   input  logic        ldr_req,
   input  logic [12:0] ldr_addr,
   input  logic [7:0]  ldr_wdata,
   output logic        ldr_ack,
   output logic        mem_en,
   output logic        mem_we,
   output logic [12:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic [1:0]  cfg_mirror,
   output logic        ciram_ce,
   output logic        ciram_a10
);

   localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIMIT);

   arb_state_t          state;
   logic [STARVE_W-1:0] starve_cnt;
   logic                rd_pend;
   logic                ldr_win;

   // loader takes the bus when alone or once the PPU has had its quota of grants
   always_comb begin
      ldr_win = ldr_req && (!ppu_req || starve_cnt == LIM);
   end

   // transaction FSM; direction is latched at grant since requests are only looked at in IDLE
   always_ff @(posedge MasterClk) begin
      if (!nRST) begin
         state      <= IDLE;
         starve_cnt <= '0;
         rd_pend    <= 1'b0;
         ppu_rdata  <= 8'h00;
         ppu_ack    <= 1'b0;
         ldr_ack    <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         mem_en  <= 1'b0;
         mem_we  <= 1'b0;
         ppu_ack <= 1'b0;
         ldr_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (!ldr_req) starve_cnt <= '0;
               if (ldr_win) begin
                  state      <= LDR_WR;
                  starve_cnt <= '0;
                  mem_en     <= 1'b1;
                  mem_we     <= 1'b1;
                  mem_addr   <= ldr_addr;
                  mem_wdata  <= ldr_wdata;
               end else if (ppu_req) begin
                  if (ldr_req) starve_cnt <= starve_next(starve_cnt, LIM);
                  rd_pend <= ~ppu_we;
                  if (ppu_addr[13]) begin
                     state   <= DONE;
                     ppu_ack <= 1'b1;
                  end else begin
                     state     <= PPU_ISSUE;
                     mem_en    <= 1'b1;
                     mem_we    <= ppu_we;
                     mem_addr  <= ppu_addr[12:0];
                     mem_wdata <= ppu_wdata;
                  end
               end
            end
            PPU_ISSUE: state <= PPU_CAPT;
            PPU_CAPT: begin
               if (rd_pend) ppu_rdata <= mem_rdata;
               state   <= DONE;
               ppu_ack <= 1'b1;
            end
            LDR_WR: begin
               state   <= DONE;
               ldr_ack <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   nt_mirror_decode u_nt_mirror_decode (
      .cfg_mirror (cfg_mirror),
      .a13        (ppu_addr[13]),
      .a11        (ppu_addr[11]),
      .a10        (ppu_addr[10]),
      .ciram_ce   (ciram_ce),
      .ciram_a10  (ciram_a10)
   );

endmodule

// File: tb/tb_chr_bus_arbiter.sv
// tb_chr_bus_arbiter: vector table, directed corner cases and random traffic against a transaction model
module tb_chr_bus_arbiter;

   localparam int LIM = 8;

   logic        MasterClk;
   logic        nRST;
   logic        ppu_req;
   logic        ppu_we;
   logic [13:0] ppu_addr;
   logic [7:0]  ppu_wdata;
   logic [7:0]  ppu_rdata;
   logic        ppu_ack;
   logic        ldr_req;
   logic [12:0] ldr_addr;
   logic [7:0]  ldr_wdata;
   logic        ldr_ack;
   logic        mem_en;
   logic        mem_we;
   logic [12:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [1:0]  cfg_mirror;
   logic        ciram_ce;
   logic        ciram_a10;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [1:0]  m;
      logic [13:0] a;
      logic        ce;
      logic        a10;
   } nt_vec_t;

   nt_vec_t     tbl [8];
   logic [7:0]  ram [8192];
   logic [7:0]  shadow [8192];
   logic [12:0] wq [$];
   logic [7:0]  exp_rd;

   chr_bus_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .MasterClk  (MasterClk),
      .nRST       (nRST),
      .ppu_req    (ppu_req),
      .ppu_we     (ppu_we),
      .ppu_addr   (ppu_addr),
      .ppu_wdata  (ppu_wdata),
      .ppu_rdata  (ppu_rdata),
      .ppu_ack    (ppu_ack),
      .ldr_req    (ldr_req),
      .ldr_addr   (ldr_addr),
      .ldr_wdata  (ldr_wdata),
      .ldr_ack    (ldr_ack),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .cfg_mirror (cfg_mirror),
      .ciram_ce   (ciram_ce),
      .ciram_a10  (ciram_a10)
   );

   initial MasterClk = 1'b0;
   always #5 MasterClk = ~MasterClk;

   // external CHR RAM: synchronous write, read data one cycle after enable
   always @(posedge MasterClk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else mem_rdata <= ram[mem_addr];
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one complete request/ack handshake from a single requester
   task automatic xact(input bit ldr, input logic we, input logic [13:0] a, input logic [7:0] d,
                       output int lat, output int en_n, output int we_n,
                       output logic [12:0] ma, output logic [7:0] md, output logic [7:0] rd);
      lat = 0; en_n = 0; we_n = 0; ma = '0; md = '0; rd = '0;
      @(negedge MasterClk);
      if (ldr) begin
         ldr_req = 1'b1; ldr_addr = a[12:0]; ldr_wdata = d;
      end else begin
         ppu_req = 1'b1; ppu_we = we; ppu_addr = a; ppu_wdata = d;
      end
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(posedge MasterClk); #1;
         if (mem_en) begin en_n++; ma = mem_addr; md = mem_wdata; end
         if (mem_we) we_n++;
         if (ldr ? ldr_ack : ppu_ack) begin lat = i; rd = ppu_rdata; end
      end
      ppu_req = 1'b0;
      ldr_req = 1'b0;
      @(posedge MasterClk); #1;
      chk("ack_single_pulse", {30'd0, ppu_ack, ldr_ack}, 32'd0);
   endtask

   int          lat, en_n, we_n, n_ppu, k;
   logic [12:0] ma;
   logic [7:0]  md, rd, d;
   logic [13:0] a;
   bit          got;

   initial begin
      tbl[0] = '{2'b00, 14'h2400, 1'b0, 1'b1};
      tbl[1] = '{2'b00, 14'h2800, 1'b0, 1'b0};
      tbl[2] = '{2'b01, 14'h2800, 1'b0, 1'b1};
      tbl[3] = '{2'b01, 14'h2400, 1'b0, 1'b0};
      tbl[4] = '{2'b10, 14'h2C00, 1'b0, 1'b0};
      tbl[5] = '{2'b11, 14'h2000, 1'b0, 1'b1};
      tbl[6] = '{2'b00, 14'h0400, 1'b1, 1'b1};
      tbl[7] = '{2'b11, 14'h1FFF, 1'b1, 1'b1};

      nRST = 1'b0; ppu_req = 1'b0; ppu_we = 1'b0; ppu_addr = '0; ppu_wdata = '0;
      ldr_req = 1'b0; ldr_addr = '0; ldr_wdata = '0; cfg_mirror = 2'b00;
      repeat (3) @(posedge MasterClk);
      #1;
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_ppu_ack", ppu_ack, 0);
      chk("rst_ldr_ack", ldr_ack, 0);
      chk("rst_ppu_rdata", ppu_rdata, 0);
      @(negedge MasterClk);
      nRST = 1'b1;
      exp_rd = 8'h00;

      // nametable decode table, including a live mirroring change
      for (int i = 0; i < 8; i++) begin
         cfg_mirror = tbl[i].m;
         ppu_addr = tbl[i].a;
         #1;
         chk($sformatf("nt_ce[%0d]", i), ciram_ce, tbl[i].ce);
         chk($sformatf("nt_a10[%0d]", i), ciram_a10, tbl[i].a10);
      end

      // loader preloads 0x123 then the PPU reads it back
      xact(1, 1'b1, 14'h0123, 8'hA5, lat, en_n, we_n, ma, md, rd);
      shadow[13'h123] = 8'hA5; wq.push_back(13'h123);
      chk("pre_ldr_lat", lat, 2);
      xact(0, 1'b0, 14'h0123, 8'h00, lat, en_n, we_n, ma, md, rd);
      exp_rd = 8'hA5;
      chk("rd123_lat", lat, 3);
      chk("rd123_en_cycles", en_n, 1);
      chk("rd123_we_cycles", we_n, 0);
      chk("rd123_addr", ma, 13'h123);
      chk("rd123_data", rd, 8'hA5);

      // loader write at top of CHR space, then PPU read of it
      xact(1, 1'b1, 14'h1FFF, 8'h3C, lat, en_n, we_n, ma, md, rd);
      shadow[13'h1FFF] = 8'h3C; wq.push_back(13'h1FFF);
      chk("ldr1fff_lat", lat, 2);
      chk("ldr1fff_we_cycles", we_n, 1);
      chk("ldr1fff_addr", ma, 13'h1FFF);
      chk("ldr1fff_data", md, 8'h3C);
      chk("ldr1fff_rdata_hold", ppu_rdata, exp_rd);
      xact(0, 1'b0, 14'h1FFF, 8'h00, lat, en_n, we_n, ma, md, rd);
      exp_rd = 8'h3C;
      chk("rd1fff_lat", lat, 3);
      chk("rd1fff_data", rd, 8'h3C);

      // nametable access bypasses CHR RAM
      cfg_mirror = 2'b01;
      xact(0, 1'b0, 14'h2800, 8'h00, lat, en_n, we_n, ma, md, rd);
      chk("nt2800_lat", lat, 1);
      chk("nt2800_en_cycles", en_n, 0);
      chk("nt2800_rdata_hold", rd, exp_rd);
      chk("nt2800_ce", ciram_ce, 0);
      chk("nt2800_a10", ciram_a10, 1);

      // starvation guard: loader waits through exactly LIM back-to-back PPU grants
      @(negedge MasterClk);
      ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 14'h1FFF;
      ldr_req = 1'b1; ldr_addr = 13'h0AAA; ldr_wdata = 8'h5E;
      n_ppu = 0; got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge MasterClk); #1;
         if (ppu_ack) n_ppu++;
         if (ldr_ack) got = 1'b1;
      end
      ppu_req = 1'b0; ldr_req = 1'b0;
      shadow[13'h0AAA] = 8'h5E; wq.push_back(13'h0AAA);
      chk("starve_ldr_acked", got, 1);
      chk("starve_ppu_grants", n_ppu, LIM);
      chk("starve_rdata", ppu_rdata, 8'h3C);
      repeat (2) @(posedge MasterClk);

      // reset while a read sits in the capture state
      @(negedge MasterClk);
      ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 14'h0AAA;
      repeat (2) @(posedge MasterClk);
      #1;
      nRST = 1'b0;
      got = 1'b0;
      @(posedge MasterClk); #1;
      got = ppu_ack;
      ppu_req = 1'b0;
      chk("midrst_no_ack", got, 0);
      chk("midrst_mem_en", mem_en, 0);
      chk("midrst_mem_addr", mem_addr, 0);
      chk("midrst_rdata", ppu_rdata, 0);
      @(posedge MasterClk); #1;
      chk("midrst_still_no_ack", ppu_ack, 0);
      @(negedge MasterClk);
      nRST = 1'b1;
      exp_rd = 8'h00;
      xact(0, 1'b0, 14'h0AAA, 8'h00, lat, en_n, we_n, ma, md, rd);
      exp_rd = 8'h5E;
      chk("postrst_lat", lat, 3);
      chk("postrst_data", rd, 8'h5E);

      // random single-requester traffic against a transaction-level memory model
      for (int t = 0; t < 150; t++) begin
         k = $urandom_range(0, 3);
         a = 14'($urandom);
         d = 8'($urandom);
         case (k)
            0: begin
               a = {1'b0, wq[$urandom_range(0, wq.size() - 1)]};
               xact(0, 1'b0, a, d, lat, en_n, we_n, ma, md, rd);
               exp_rd = shadow[a[12:0]];
               chk("rnd_rd_lat", lat, 3);
               chk("rnd_rd_en", en_n, 1);
               chk("rnd_rd_we", we_n, 0);
               chk("rnd_rd_addr", ma, a[12:0]);
               chk("rnd_rd_data", rd, exp_rd);
            end
            1: begin
               a[13] = 1'b0;
               xact(0, 1'b1, a, d, lat, en_n, we_n, ma, md, rd);
               chk("rnd_wr_lat", lat, 3);
               chk("rnd_wr_en", en_n, 1);
               chk("rnd_wr_we", we_n, 1);
               chk("rnd_wr_addr", ma, a[12:0]);
               chk("rnd_wr_data", md, d);
               chk("rnd_wr_rdata_hold", rd, exp_rd);
               shadow[a[12:0]] = d; wq.push_back(a[12:0]);
            end
            2: begin
               a[13] = 1'b1;
               xact(0, 1'($urandom), a, d, lat, en_n, we_n, ma, md, rd);
               chk("rnd_nt_lat", lat, 1);
               chk("rnd_nt_en", en_n, 0);
               chk("rnd_nt_rdata_hold", rd, exp_rd);
            end
            default: begin
               xact(1, 1'b1, a, d, lat, en_n, we_n, ma, md, rd);
               chk("rnd_ldr_lat", lat, 2);
               chk("rnd_ldr_en", en_n, 1);
               chk("rnd_ldr_we", we_n, 1);
               chk("rnd_ldr_addr", ma, a[12:0]);
               chk("rnd_ldr_data", md, d);
               shadow[a[12:0]] = d; wq.push_back(a[12:0]);
            end
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/chr_bus_arbiter.md
CHR_BUS_ARBITER -- requirements
Module: chr_bus_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 8, max consecutive PPU grants while a loader request waits (1..15).
REQ-002 Port: MasterClk  in  1  sole clock, all state on rising edge.
REQ-003 Port: nRST  in  1  synchronous, active-low reset.
REQ-004 Port: ppu_req  in  1  PPU access request, held high until ppu_ack.
REQ-005 Port: ppu_we  in  1  1 = PPU write, 0 = read; qualified by ppu_req.
REQ-006 Port: ppu_addr  in  14  PPU address A13..A0.
REQ-007 Port: ppu_wdata  in  8  PPU write data.
REQ-008 Port: ppu_rdata  out  8  PPU read data, valid while ppu_ack = 1.
REQ-009 Port: ppu_ack  out  1  one-cycle completion pulse.
REQ-010 Port: ldr_req  in  1  loader CHR write request, held until ldr_ack.
REQ-011 Port: ldr_addr  in  13  loader CHR address.
REQ-012 Port: ldr_wdata  in  8  loader write data.
REQ-013 Port: ldr_ack  out  1  one-cycle completion pulse.
REQ-014 Port: mem_en, mem_we  out  1 each  CHR RAM enable/write strobe, registered.
REQ-015 Port: mem_addr  out  13; mem_wdata  out  8  CHR RAM address/data, registered.
REQ-016 Port: mem_rdata  in  8  CHR RAM read data, valid one cycle after mem_en read.
REQ-017 Port: cfg_mirror  in  2  00 vertical, 01 horizontal, 10 single-screen A, 11 single-screen B.
REQ-018 Port: ciram_ce  out  1; ciram_a10  out  1  nametable RAM select/bank, combinational.

Function
REQ-019 States SHALL be IDLE, PPU_ISSUE, PPU_CAPT, LDR_WR, DONE; encoding 3 bits.
REQ-020 In IDLE, a PPU request SHALL win over a pending loader request unless starve_cnt = STARVE_LIMIT.
REQ-021 starve_cnt (4 bits) SHALL increment on each PPU grant while ldr_req = 1, saturate at STARVE_LIMIT, clear on loader grant or whenever ldr_req = 0 in IDLE.
REQ-022 PPU grant with ppu_addr[13] = 0: IDLE -> PPU_ISSUE; mem_en = 1, mem_we = ppu_we, mem_addr = ppu_addr[12:0], mem_wdata = ppu_wdata for exactly that cycle.
REQ-023 PPU_ISSUE -> PPU_CAPT; in PPU_CAPT, ppu_rdata SHALL register mem_rdata on reads and hold its prior value on writes.
REQ-024 PPU_CAPT -> DONE; ppu_ack = 1 only in DONE; read latency from grant edge to ack = 3 cycles.
REQ-025 PPU grant with ppu_addr[13] = 1: IDLE -> DONE directly, no mem_en, ppu_rdata unchanged, ppu_ack after 1 cycle.
REQ-026 Loader grant: IDLE -> LDR_WR; mem_en = mem_we = 1 with ldr_addr/ldr_wdata for one cycle; then DONE with ldr_ack = 1.
REQ-027 DONE SHALL ignore all requests and return to IDLE next cycle; exactly one ack pulses per transaction.
REQ-028 Request inputs SHALL be sampled only in IDLE; changes in other states have no effect on the in-flight transaction.
REQ-029 Simultaneous ppu_req and ldr_req in IDLE with starve_cnt < STARVE_LIMIT: PPU granted, loader waits.
REQ-030 ciram_ce SHALL equal ~ppu_addr[13]... SHALL be active-low select: ciram_ce = ~ppu_addr[13].
REQ-031 ciram_a10 SHALL be ppu_addr[10] (00), ppu_addr[11] (01), 0 (10), 1 (11); cfg_mirror changes take effect immediately.
REQ-032 mem_en, mem_we SHALL be 0 in every state other than PPU_ISSUE and LDR_WR.

Reset
REQ-033 nRST = 0 at a rising edge SHALL force IDLE, starve_cnt = 0, ppu_rdata = 8'h00, ppu_ack = ldr_ack = 0, mem_en = mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-034 Reset mid-transaction SHALL abort it with no ack; the requester re-issues.

Structure
REQ-035 State encodings and mirror-mode codes SHALL live in the shared cartridge package for reuse by the cartridge top.
REQ-036 One sub-module, nt_mirror_decode, SHALL implement REQ-030/031 combinationally.

Verification
REQ-037 PPU read 0x0123, RAM[0x123] = 8'hA5 -> mem_en one cycle, ppu_ack 3 cycles after grant with ppu_rdata = 8'hA5.
REQ-038 Loader write 0x1FFF/8'h3C -> one mem_we cycle at 0x1FFF, ldr_ack next cycle; later PPU read 0x1FFF returns 8'h3C.
REQ-039 ldr_req held with back-to-back PPU reads, STARVE_LIMIT = 8 -> loader granted after exactly 8 PPU grants.
REQ-040 cfg_mirror = 01, ppu_addr = 0x2800 -> ciram_ce = 0, ciram_a10 = 1, ppu_ack after 1 cycle, mem_en stays 0.
REQ-041 nRST low during PPU_CAPT -> no ppu_ack, all outputs at reset values next cycle, fresh request then completes normally.
